// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the Hi/Lo pair; radix-2 iteration on
// operand magnitudes with a single sign fix-up cycle before the Hi/Lo write.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MSUB  = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  state_e             state, state_n;
  op_e                op_in, op_q;
  logic [CNT_W-1:0]   cnt;
  logic               sa, sb;
  logic [WIDTH-1:0]   dv;
  logic [2*WIDTH-1:0] p;
  logic               divzero_q;

  logic               accept;
  logic               in_signed, in_div, div_zero;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               q_div;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_step;

  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] fix_hilo;

  assign op_in = op_e'(Op);

  always_comb begin
    accept    = Start && !Flush && (state == S_IDLE || state == S_DONE);
    in_signed = op_in inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    in_div    = op_in inside {OP_DIV, OP_DIVU};
    div_zero  = in_div && (B == '0);
    a_neg     = in_signed && A[WIDTH-1];
    b_neg     = in_signed && B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    q_div     = op_q inside {OP_DIV, OP_DIVU};
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (op_in inside {OP_MTHI, OP_MTLO} || div_zero) state_n = S_DONE;
          else                                              state_n = S_CALC;
        end else if (state == S_DONE) begin
          state_n = S_IDLE;
        end
      end
      S_CALC:  if (cnt == '0) state_n = S_FIX;
      S_FIX:   state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (Flush) state_n = S_IDLE;
  end

  // p holds {partial product, remaining multiplier} for multiply and
  // {partial remainder, dividend/quotient bits} for divide.
  always_comb begin
    mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? dv : {WIDTH{1'b0}})};
    mul_step = {mul_sum, p[WIDTH-1:1]};
    div_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, dv};
    div_sub  = div_sh[WIDTH-1:0] - dv;
    div_step = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
  end

  always_comb begin
    neg  = sa ^ sb;
    prod = neg ? -p : p;
    quot = neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rem  = sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MULT, OP_MULTU: fix_hilo = prod;
      OP_MADD:           fix_hilo = {Hi, Lo} + prod;
      OP_MSUB:           fix_hilo = {Hi, Lo} - prod;
      OP_DIV, OP_DIVU:   fix_hilo = {rem, quot};
      default:           fix_hilo = {Hi, Lo};
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      op_q      <= OP_MULT;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dv        <= '0;
      p         <= '0;
      divzero_q <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      state     <= state_n;
      divzero_q <= 1'b0;
      if (!Flush) begin
        case (state)
          S_IDLE, S_DONE: begin
            if (accept) begin
              op_q <= op_in;
              sa   <= a_neg;
              sb   <= b_neg;
              cnt  <= CNT_W'(WIDTH - 1);
              case (op_in)
                OP_MTHI: Hi <= A;
                OP_MTLO: Lo <= A;
                default: begin
                  if (div_zero) begin
                    divzero_q <= 1'b1;
                  end else if (in_div) begin
                    dv <= b_mag;
                    p  <= {{WIDTH{1'b0}}, a_mag};
                  end else begin
                    dv <= a_mag;
                    p  <= {{WIDTH{1'b0}}, b_mag};
                  end
                end
              endcase
            end
          end
          S_CALC: begin
            p   <= q_div ? div_step : mul_step;
            cnt <= cnt - 1'b1;
          end
          S_FIX: {Hi, Lo} <= fix_hilo;
          default: ;
        endcase
      end
    end
  end

  assign Busy    = (state == S_CALC) || (state == S_FIX);
  assign Done    = (state == S_DONE);
  assign DivZero = divzero_q;

endmodule
